// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/ack read to imem, buffers one instruction for decode.
// Optional PC_ALIGN_CHECK_EN adds a sticky misaligned flag and a halt state; without it targets are forced word-aligned.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmOp,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misaligned,
    output logic [1:0]  state_dbg
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;
`endif

    state_t      state, state_d;
    logic [31:0] fetch_pc, fetch_pc_d;
    logic        kill, kill_d;
    logic        valid_d;
    logic [31:0] instr_d, instr_pc_d;
    logic [31:0] target, flush_tgt;
    logic        redirect, accept, addr_hold;
`ifdef PC_ALIGN_CHECK_EN
    logic        mis_q, mis_d;
`endif

    assign accept    = instr_valid & instr_ready;
    // The address must not move while a request is waiting for its ack.
    assign addr_hold = (state == S_REQ) && !imem_ack;
    assign state_dbg = state;

    always_comb begin
        redirect = 1'b0;
        target   = instr_pc + 32'd4;
        case (PCSrc)
            2'b01: begin target = instr_pc + ImmOp; redirect = 1'b1; end
            2'b10: begin target = ImmOp;            redirect = 1'b1; end
            default: ;
        endcase
        flush_tgt = flush_pc;
`ifndef PC_ALIGN_CHECK_EN
        target[1:0]    = 2'b00;
        flush_tgt[1:0] = 2'b00;
`endif
    end

    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        kill_d     = kill;
        valid_d    = instr_valid;
        instr_d    = instr;
        instr_pc_d = instr_pc;
`ifdef PC_ALIGN_CHECK_EN
        mis_d      = mis_q;
`endif
        if (flush) begin
            fetch_pc_d = flush_tgt;
            valid_d    = 1'b0;
            state_d    = S_REQ;
            kill_d     = (state == S_REQ) && !imem_ack;
`ifdef PC_ALIGN_CHECK_EN
            mis_d = (flush_pc[1:0] != 2'b00);
            // A bad restart with a read still in flight halts once that read drains.
            if (mis_d && !kill_d) state_d = S_HALT;
`endif
        end else begin
            case (state)
                S_BOOT: state_d = S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        if (kill) begin
                            kill_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                            if (mis_q) state_d = S_HALT;
`endif
                        end else begin
                            valid_d    = 1'b1;
                            instr_d    = imem_rdata;
                            instr_pc_d = fetch_pc;
                            state_d    = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        valid_d    = 1'b0;
                        fetch_pc_d = target;
                        state_d    = S_REQ;
`ifdef PC_ALIGN_CHECK_EN
                        if (redirect && (target[1:0] != 2'b00)) begin
                            mis_d   = 1'b1;
                            state_d = S_HALT;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
`ifdef PC_ALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            kill        <= kill_d;
            instr_valid <= valid_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            imem_req    <= (state_d == S_REQ);
            if (!addr_hold) imem_addr <= fetch_pc_d;
`ifdef PC_ALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that owns the program counter, issues reads to instruction memory over a req/ack handshake, and presents one fetched instruction at a time to decode. It sits upstream of the control unit. On acceptance of each instruction it consumes that instruction's resolved `PCSrc` and `ImmOp` to choose the next fetch address. It also supports an asynchronous-to-pipeline flush (trap/restart) that can kill an in-flight memory read.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PCSrc` in 2: next-PC select for the instruction accepted this cycle.
  - 00: PC+4.
  - 01: PC+ImmOp.
  - 10: ImmOp.
  - 11: treated as 00.
- `ImmOp` in 32: branch offset (01) or absolute target (10); sampled only on accept.
- `flush` in 1: discard buffered and in-flight instruction, restart at `flush_pc`.
- `flush_pc` in 32: restart address, sampled when `flush`=1.
- `imem_req` out 1: read request; held high until `imem_ack`.
- `imem_addr` out 32: read address; stable while `imem_req`=1.
- `imem_ack` in 1: read data valid this cycle; only meaningful while `imem_req`=1.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `instr` out 32: buffered instruction to decode.
- `instr_pc` out 32: address of `instr`.
- `instr_valid` out 1: output buffer holds a valid instruction.
- `instr_ready` in 1: decode accepts; accept = `instr_valid & instr_ready`.
- `misaligned` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- Registers:
  - `fetch_pc` (32).
  - FSM state.
  - `kill` (1).
  - Output buffer {`instr_valid`, `instr`, `instr_pc`}.
- States:
  - S_BOOT: one cycle after reset; `imem_req`=0; → S_REQ.
  - S_REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
    - On `imem_ack` with `kill`=0: load buffer {`imem_rdata`, `fetch_pc`}, `instr_valid`←1, → S_WAIT.
    - On `imem_ack` with `kill`=1: discard data, `kill`←0, stay S_REQ; the new request uses the updated `fetch_pc`.
  - S_WAIT: `imem_req`=0, buffer valid; on accept, compute the next PC, `instr_valid`←0, → S_REQ.
  - S_HALT (only with macro): `imem_req`=0, `instr_valid`=0; exited only by `flush` or `rst`.
- Next PC on accept, with 32-bit wrap-around (no overflow detection):
  - 00/11: `instr_pc`+4.
  - 01: `instr_pc`+`ImmOp`.
  - 10: `ImmOp`.
- Flush has priority over accept and over `imem_ack`.
  - Effect: `fetch_pc`←`flush_pc`, `instr_valid`←0.
  - If flush arrives in S_REQ with no `imem_ack` that cycle: `kill`←1 and stay S_REQ. `imem_addr` keeps its old value until the ack, so address stability is preserved.
  - If flush coincides with `imem_ack`: data discarded, `kill` stays 0, stay S_REQ; the next cycle requests `flush_pc`.
  - In S_WAIT/S_BOOT/S_HALT: → S_REQ.
- At most one memory request is outstanding. No speculative fetch; the decode PC is always architecturally correct.
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `misaligned`=0, `kill`=0, `fetch_pc`=`RESET_PC`, state S_BOOT.
- Reset mid-request abandons the transaction. Instruction memory shares `rst` and must drop any pending ack.

## Timing
- Fetch latency: first `imem_req` is one cycle after `rst` deasserts. Data reaches `instr` the cycle after `imem_ack`.
- Zero-wait memory (ack in the same cycle as req): one instruction per 2 cycles at best.
- `imem_addr` and `imem_req` are driven from registers only (no combinational path from `PCSrc`/`ImmOp`/`flush`).
- `instr`, `instr_pc` and `instr_valid` are registered. `instr` and `instr_pc` hold while `instr_valid`=1 and not accepted.
- `PCSrc` and `ImmOp` may be combinational from decode of `instr` in the same cycle.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - On an accepted redirect (01/10) whose target[1:0]≠00: set `misaligned`, clear `instr_valid`, → S_HALT.
  - A misaligned `flush_pc` is treated the same way.
  - `flush` with an aligned `flush_pc` clears `misaligned` and resumes.
- Undefined: target[1:0] forced to 00, `misaligned` tied 0, S_HALT absent.

## Test plan
- Reset release, memory acks 1 cycle after req with rdata=32'h00500093 → `imem_addr`=0, then `instr`=32'h00500093, `instr_pc`=0, then next request to address 4.
- Accept `instr_pc`=32'h10 with `PCSrc`=01, `ImmOp`=32'hFFFF_FFF0 → next `imem_addr`=32'h0; with `PCSrc`=10, `ImmOp`=32'h200 → `imem_addr`=32'h200.
- `instr_ready`=0 for 5 cycles → `instr` and `instr_pc` stable, `imem_req`=0 throughout; accept on cycle 6 → req next cycle.
- Request to 32'h8 with a 4-cycle ack; `flush`=1, `flush_pc`=32'h400 at cycle 2 → `imem_addr` stays 8 until ack, data discarded, `instr_valid` stays 0, next `imem_addr`=32'h400.
- `flush` coincident with `imem_ack` → no instruction presented; next request to `flush_pc`.
- With `PC_ALIGN_CHECK_EN`: accept `PCSrc`=10, `ImmOp`=32'h102 → `misaligned`=1, `imem_req`=0 indefinitely until `flush_pc`=32'h100 resumes. Without the macro: `imem_addr`=32'h100.
